csr_apb_wr_bank: RTL and testbench

APB3 responder for the CSR block. It decodes APB transfers into a bank of eight 8-bit control registers and commits writes on a byte address. Register contents are exported as a flat bus that feeds the 8:1 read-select mux, with a one-hot per-register write strobe. It also serves APB reads, applies configurable wait states, and raises error responses for bad addresses and for writes to locked registers.

---
 rtl/csr_apb_wr_bank.sv | 144 ++++++++++++++
 tb/tb_csr_apb_wr_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_apb_wr_bank.sv
// APB3 responder for a bank of eight 8-bit CSRs with configurable wait states.
// Register 7 bit 7 is a sticky LOCK that turns every later write into an error.
module csr_apb_wr_bank #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic              pready,
  output logic [7:0]        prdata,
  output logic              pslverr,
  output logic [63:0]       regs_q,
  output logic [7:0]        wr_strobe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [7:0]        prdata_q, prdata_d;
  logic [7:0]        wr_strobe_q, wr_strobe_d;
  logic [63:0]       regs_d;

  logic              enter_ready;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wr;
  logic              addr_ok;
  logic              lock;

  assign lock = regs_q[63];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = prdata_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    enter_ready = 1'b0;
    cur_addr    = addr_q;
    cur_wr      = wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          addr_d   = paddr;
          wr_d     = pwrite;
          wdata_d  = pwdata;
          // Zero-wait entry to READY decodes straight from the bus.
          cur_addr = paddr;
          cur_wr   = pwrite;
          if (WAIT_STATES == 0) begin
            state_d     = S_READY;
            enter_ready = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 2'd1;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 2'(WAIT_STATES)) begin
          state_d     = S_READY;
          enter_ready = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
        if (psel && wr_q && !pslverr_q) begin
          regs_d[{addr_q[2:0], 3'b000} +: 8] = wdata_q;
          wr_strobe_d[addr_q[2:0]]           = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    addr_ok = (cur_addr[ADDR_W-1:3] == '0);
    if (enter_ready) begin
      pready_d  = 1'b1;
      pslverr_d = !addr_ok || (cur_wr && lock);
      if (!addr_ok) begin
        prdata_d = '0;
      end else if (!cur_wr) begin
        prdata_d = regs_q[{cur_addr[2:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      wr_strobe_q <= '0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      wr_strobe_q <= wr_strobe_d;
      regs_q      <= regs_d;
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_csr_apb_wr_bank.sv
// Directed bench for csr_apb_wr_bank: three instances at WAIT_STATES 1, 3 and 0,
// a vector table for single transfers and hand sequences for abort/reset/protocol cases.
module tb_csr_apb_wr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn[3];
  logic        psel[3];
  logic        penable[3];
  logic        pwrite[3];
  logic [7:0]  paddr[3];
  logic [7:0]  pwdata[3];
  logic        pready[3];
  logic [7:0]  prdata[3];
  logic        pslverr[3];
  logic [63:0] regs[3];
  logic [7:0]  strobe[3];

  int total = 0;
  int bad   = 0;
  int ws_of[3] = '{1, 3, 0};
  logic [63:0] model[3];

  csr_apb_wr_bank #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
    .pclk(clk), .presetn(rstn[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .regs_q(regs[0]), .wr_strobe(strobe[0])
  );

  csr_apb_wr_bank #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (
    .pclk(clk), .presetn(rstn[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .regs_q(regs[1]), .wr_strobe(strobe[1])
  );

  csr_apb_wr_bank #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
    .pclk(clk), .presetn(rstn[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .pready(pready[2]),
    .prdata(prdata[2]), .pslverr(pslverr[2]), .regs_q(regs[2]), .wr_strobe(strobe[2])
  );

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    bit         err;
    logic [7:0] rd;
    bit         chk_rd;
    logic [7:0] strb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int k, bit wr, logic [7:0] a, logic [7:0] d, bit err,
                              logic [7:0] rd, bit chk_rd, logic [7:0] strb);
    vec_t v;
    v = '{k, wr, a, d, err, rd, chk_rd, strb};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1 with the bus idle; returns at posedge+1 of the cycle after READY.
  task automatic xfer(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output logic err, output logic [7:0] rd);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    lat = 0; err = 1'bx; rd = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (pready[k]) begin
        lat = n; err = pslverr[k]; rd = prdata[k];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       err;
    logic [7:0] rd;
    vec_t       v;

    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0; model[k] = '0;
    end

    // WAIT_STATES=1: spec write, full fill, readback under lock, lock errors, bad address
    add(0, 1, 8'h03, 8'hA5, 0, 8'h00, 0, 8'h08);
    add(0, 1, 8'h00, 8'h11, 0, 8'h00, 0, 8'h01);
    add(0, 1, 8'h01, 8'h22, 0, 8'h00, 0, 8'h02);
    add(0, 1, 8'h02, 8'h33, 0, 8'h00, 0, 8'h04);
    add(0, 1, 8'h03, 8'h44, 0, 8'h00, 0, 8'h08);
    add(0, 1, 8'h04, 8'h55, 0, 8'h00, 0, 8'h10);
    add(0, 1, 8'h05, 8'h66, 0, 8'h00, 0, 8'h20);
    add(0, 1, 8'h06, 8'h77, 0, 8'h00, 0, 8'h40);
    add(0, 1, 8'h07, 8'h88, 0, 8'h00, 0, 8'h80);
    add(0, 0, 8'h00, 8'h00, 0, 8'h11, 1, 8'h00);
    add(0, 0, 8'h01, 8'h00, 0, 8'h22, 1, 8'h00);
    add(0, 0, 8'h02, 8'h00, 0, 8'h33, 1, 8'h00);
    add(0, 0, 8'h03, 8'h00, 0, 8'h44, 1, 8'h00);
    add(0, 0, 8'h04, 8'h00, 0, 8'h55, 1, 8'h00);
    add(0, 0, 8'h05, 8'h00, 0, 8'h66, 1, 8'h00);
    add(0, 0, 8'h06, 8'h00, 0, 8'h77, 1, 8'h00);
    add(0, 0, 8'h07, 8'h00, 0, 8'h88, 1, 8'h00);
    add(0, 1, 8'h02, 8'h55, 1, 8'h00, 0, 8'h00);
    add(0, 1, 8'h07, 8'h00, 1, 8'h00, 0, 8'h00);
    add(0, 0, 8'h02, 8'h00, 0, 8'h33, 1, 8'h00);
    add(0, 0, 8'h07, 8'h00, 0, 8'h88, 1, 8'h00);
    add(0, 1, 8'h08, 8'hFF, 1, 8'h00, 1, 8'h00);
    add(0, 0, 8'h08, 8'h00, 1, 8'h00, 1, 8'h00);
    // WAIT_STATES=0: back-to-back write/read pairs, bad address, lock sequence
    add(2, 1, 8'h00, 8'h5A, 0, 8'h00, 0, 8'h01);
    add(2, 0, 8'h00, 8'h00, 0, 8'h5A, 1, 8'h00);
    add(2, 1, 8'h05, 8'hC3, 0, 8'h00, 0, 8'h20);
    add(2, 0, 8'h05, 8'h00, 0, 8'hC3, 1, 8'h00);
    add(2, 0, 8'h08, 8'h00, 1, 8'h00, 1, 8'h00);
    add(2, 0, 8'h00, 8'h00, 0, 8'h5A, 1, 8'h00);
    add(2, 1, 8'h10, 8'hFF, 1, 8'h00, 1, 8'h00);
    add(2, 1, 8'h07, 8'h80, 0, 8'h00, 0, 8'h80);
    add(2, 1, 8'h02, 8'h55, 1, 8'h00, 0, 8'h00);
    add(2, 1, 8'h07, 8'h00, 1, 8'h00, 0, 8'h00);
    add(2, 0, 8'h07, 8'h00, 0, 8'h80, 1, 8'h00);
    add(2, 0, 8'h02, 8'h00, 0, 8'h00, 1, 8'h00);
    add(2, 0, 8'h05, 8'h00, 0, 8'hC3, 1, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d pready", k), 64'(pready[k]), 64'h0);
      check($sformatf("rst%0d pslverr", k), 64'(pslverr[k]), 64'h0);
      check($sformatf("rst%0d prdata", k), 64'(prdata[k]), 64'h0);
      check($sformatf("rst%0d regs", k), regs[k], 64'h0);
      check($sformatf("rst%0d strobe", k), 64'(strobe[k]), 64'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      xfer(v.k, v.wr, v.a, v.d, lat, err, rd);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(ws_of[v.k] + 1));
      check($sformatf("v%0d pslverr", i), 64'(err), 64'(v.err));
      if (v.chk_rd) check($sformatf("v%0d prdata", i), 64'(rd), 64'(v.rd));
      check($sformatf("v%0d strobe", i), 64'(strobe[v.k]), 64'(v.strb));
      if (v.wr && !v.err && v.a < 8) model[v.k][int'(v.a) * 8 +: 8] = v.d;
      check($sformatf("v%0d regs", i), regs[v.k], model[v.k]);
    end

    // Protocol violation on the zero-wait instance: enable without setup is ignored
    psel[2] = 1'b1; penable[2] = 1'b1; pwrite[2] = 1'b1; paddr[2] = 8'h01; pwdata[2] = 8'hEE;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("noset pready", 64'(pready[2]), 64'h0);
      @(posedge clk); #1;
    end
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge clk); #1;
    check("noset regs", regs[2], model[2]);
    check("noset strobe", 64'(strobe[2]), 64'h0);

    // WAIT_STATES=3: drop psel in the last wait cycle
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h01; pwdata[1] = 8'h99;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("abort pready wait", 64'(pready[1]), 64'h0);
      @(posedge clk); #1;
    end
    psel[1] = 1'b0; penable[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("abort pready after", 64'(pready[1]), 64'h0);
      check("abort strobe", 64'(strobe[1]), 64'h0);
      @(posedge clk); #1;
    end
    check("abort regs", regs[1], 64'h0);

    xfer(1, 1'b1, 8'h04, 8'h3C, lat, err, rd);
    check("ws3 wr latency", 64'(lat), 64'd4);
    check("ws3 wr pslverr", 64'(err), 64'h0);
    check("ws3 wr strobe", 64'(strobe[1]), 64'h10);
    check("ws3 wr regs", regs[1], 64'h0000_003C_0000_0000);
    xfer(1, 1'b0, 8'h04, 8'h00, lat, err, rd);
    check("ws3 rd latency", 64'(lat), 64'd4);
    check("ws3 rd prdata", 64'(rd), 64'h3C);

    // Asynchronous reset in the middle of a waited write
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h04; pwdata[1] = 8'h77;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("rstmid pready wait", 64'(pready[1]), 64'h0);
      @(posedge clk); #1;
    end
    rstn[1] = 1'b0;
    #2;
    check("rstmid pready", 64'(pready[1]), 64'h0);
    check("rstmid pslverr", 64'(pslverr[1]), 64'h0);
    check("rstmid prdata", 64'(prdata[1]), 64'h0);
    check("rstmid regs", regs[1], 64'h0);
    check("rstmid strobe", 64'(strobe[1]), 64'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("rstmid pready after", 64'(pready[1]), 64'h0);
      @(posedge clk); #1;
    end
    check("rstmid regs after", regs[1], 64'h0);
    xfer(1, 1'b0, 8'h04, 8'h00, lat, err, rd);
    check("post-rst latency", 64'(lat), 64'd4);
    check("post-rst prdata", 64'(rd), 64'h00);
    check("post-rst pslverr", 64'(err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
